// File: rtl/i2s_tx.sv
// I2S transmitter: gain-shifts and saturates mono samples, then serialises them
// on both channels with locally generated BCLK/LRCLK.
module i2s_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 24,
    parameter int unsigned BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    input  logic [$clog2(DATA_WIDTH):0]   gain_shift,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          clip,
    output logic                          underrun
);

    localparam int unsigned DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned HEAD_W = DATA_WIDTH - OUT_WIDTH + 1;

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 bclk_q, bclk_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic                 clip_q, clip_d;
    logic                 underrun_q, underrun_d;
    logic                 ready_q, ready_d;
    logic                 hold_full_q, hold_full_d;
    logic [5:0]           bit_cnt_q, bit_cnt_d;
    logic [OUT_WIDTH-1:0] hold_q, hold_d;
    logic [OUT_WIDTH-1:0] frame_q, frame_d;

    logic signed [DATA_WIDTH-1:0] shifted;
    logic [HEAD_W-1:0]            head;
    logic [OUT_WIDTH-1:0]         sat;
    logic                         sat_hit;
    logic                         accept;
    logic                         tick;
    logic                         fall_evt;
    logic                         load;
    logic [31:0]                  word;
    logic [4:0]                   bit_idx;

    always_comb begin
        shifted = $signed(sample_in) >>> gain_shift;
        // The value fits when every bit above the output sign bit matches it.
        head    = shifted[DATA_WIDTH-1:OUT_WIDTH-1];
        sat_hit = !((head == '0) || (head == '1));
        if (!sat_hit) begin
            sat = shifted[OUT_WIDTH-1:0];
        end else if (shifted[DATA_WIDTH-1]) begin
            sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        tick      = (div_q == DIV_W'(BCLK_DIV - 1));
        fall_evt  = tick && bclk_q;
        load      = fall_evt && (bit_cnt_q == 6'd62);
        accept    = sample_valid && ready_q;

        div_d     = tick ? '0 : div_q + DIV_W'(1);
        bclk_d    = tick ? ~bclk_q : bclk_q;
        bit_cnt_d = fall_evt ? bit_cnt_q + 6'd1 : bit_cnt_q;

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        frame_d     = frame_q;
        if (load && hold_full_q) begin
            frame_d     = hold_q;
            hold_full_d = 1'b0;
        end
        // accept implies holding was empty, so it never collides with the copy above
        if (accept) begin
            hold_d      = sat;
            hold_full_d = 1'b1;
        end

        ready_d    = !hold_full_d;
        clip_d     = accept && sat_hit;
        underrun_d = load && !hold_full_q;

        // Left and right slots both index the word as 31 - (bit_cnt mod 32).
        word    = 32'(frame_q) << (32 - OUT_WIDTH);
        bit_idx = ~bit_cnt_d[4:0];
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        if (fall_evt) begin
            lrclk_d = (bit_cnt_d >= 6'd31) && (bit_cnt_d <= 6'd62);
            sdata_d = word[bit_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            clip_q      <= 1'b0;
            underrun_q  <= 1'b0;
            ready_q     <= 1'b1;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= 6'd62;
            hold_q      <= '0;
            frame_q     <= '0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            clip_q      <= clip_d;
            underrun_q  <= underrun_d;
            ready_q     <= ready_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            frame_q     <= frame_d;
        end
    end

    assign sample_ready = ready_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign clip         = clip_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frames are decoded from the serial pins and
// compared against hand-computed slot words.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sample_in = '0;
    logic [5:0]  gain_shift = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, bclk, lrclk, sdata, clip, underrun;

    int checks = 0;
    int errors = 0;
    int cyc;
    int lr_bad = 0;

    logic [63:0] frames[$];
    int          ur_log[$];

    i2s_tx #(.DATA_WIDTH(32), .OUT_WIDTH(24), .BCLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .gain_shift(gain_shift),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .bclk(bclk),
        .lrclk(lrclk), .sdata(sdata), .clip(clip), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Frame decoder: samples on BCLK rises; pos 0 is slot 63, pos k is slot k-1.
    int          pos;
    logic        prev_bclk, have;
    logic [31:0] cl, cr;
    always @(negedge clk) begin
        if (rst) begin
            pos = -2; prev_bclk = 1'b0; have = 1'b0;
        end else begin
            if (underrun) ur_log.push_back(cyc);
            if (bclk && !prev_bclk) begin
                pos = (pos == 63) ? 0 : pos + 1;
                if (pos >= 0) begin
                    if (lrclk !== (pos >= 32)) lr_bad++;
                    if (pos == 0) begin
                        cr[0] = sdata;
                        if (have) frames.push_back({cl, cr});
                    end else if (pos <= 32) begin
                        cl[32-pos] = sdata;
                        have = 1'b1;
                    end else begin
                        cr[64-pos] = sdata;
                    end
                end
            end
            prev_bclk = bclk;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        frames.delete();
        ur_log.delete();
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_frames(input int n);
        int g = 0;
        while (frames.size() < n && g < 2500) begin
            @(negedge clk);
            g++;
        end
    endtask

    // Called at a negedge; returns after the accepting edge with clip as seen next cycle.
    task automatic send(input logic [31:0] d, input logic [5:0] s,
                        output bit ok, output logic clip_seen, output int acc_cyc);
        int n = 0;
        ok = 1'b0; clip_seen = 1'b0; acc_cyc = -1;
        sample_in = d; gain_shift = s; sample_valid = 1'b1;
        while (!sample_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sample_ready) begin
            acc_cyc = cyc + 1;
            @(negedge clk);
            clip_seen = clip;
            ok = 1'b1;
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bclk, lrclk, sdata, clip, underrun, sample_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=000001", {bclk, lrclk, sdata, clip, underrun, sample_ready});
        end
        @(negedge clk);
        ur_log.delete();
        frames.delete();
        rst = 1'b0;
        wait_cyc(3);
        checks++;
        if (bclk !== 1'b0) begin errors++; $display("FAIL bclk_c3 got=%b want=0", bclk); end
        wait_cyc(4);
        checks++;
        if (bclk !== 1'b1) begin errors++; $display("FAIL bclk_first_rise got=%b want=1", bclk); end
        wait_cyc(7);
        checks++;
        if (bclk !== 1'b1 || underrun !== 1'b0) begin
            errors++; $display("FAIL c7 bclk/underrun got=%b%b want=10", bclk, underrun);
        end
        wait_cyc(8);
        checks++;
        if (bclk !== 1'b0 || underrun !== 1'b1) begin
            errors++; $display("FAIL first_load bclk/underrun got=%b%b want=01", bclk, underrun);
        end
        wait_cyc(9);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_width got=%b want=0", underrun); end
        wait_frames(1);
        checks++;
        if (frames.size() < 1 || frames[0] !== 64'h0) begin
            errors++; $display("FAIL reset_frame got=%0d frames want=one zero frame", frames.size());
        end
    endtask

    task automatic test_basic();
        bit ok; logic cs; int ac;
        do_reset();
        send(32'h0012_3456, 6'd0, ok, cs, ac);
        checks++;
        if (!ok || cs !== 1'b0 || ac !== 1) begin
            errors++; $display("FAIL basic_accept ok=%0d clip=%b cyc=%0d want ok=1 clip=0 cyc=1", ok, cs, ac);
        end
        checks++;
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low got=%b want=0", sample_ready); end
        wait_cyc(7);
        checks++;
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL ready_before_load got=%b want=0", sample_ready); end
        wait_cyc(8);
        checks++;
        if (sample_ready !== 1'b1 || underrun !== 1'b0) begin
            errors++; $display("FAIL load_ready/underrun got=%b%b want=10", sample_ready, underrun);
        end
        wait_frames(2);
        checks++;
        if (frames.size() < 2 || frames[0] !== 64'h12345600_12345600) begin
            errors++; $display("FAIL basic_frame got=%h want=1234560012345600", frames.size() > 0 ? frames[0] : 64'hx);
        end
        checks++;
        if (lr_bad !== 0) begin errors++; $display("FAIL lrclk_alignment got=%0d bad bits want=0", lr_bad); end
    endtask

    task automatic test_saturation();
        logic [31:0] din  [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFF80_0000, 32'h0080_0000};
        logic [5:0]  sh   [6] = '{6'd0, 6'd0, 6'd8, 6'd40, 6'd0, 6'd0};
        logic [23:0] want [6] = '{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'h800000, 24'h7FFFFF};
        logic        wclip[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            bit ok; logic cs; int ac;
            logic [63:0] wf;
            wf = {want[i], 8'h00, want[i], 8'h00};
            do_reset();
            send(din[i], sh[i], ok, cs, ac);
            checks++;
            if (!ok || cs !== wclip[i]) begin
                errors++; $display("FAIL sat_clip[%0d] got=%b want=%b ok=%0d", i, cs, wclip[i], ok);
            end
            wait_frames(1);
            checks++;
            if (frames.size() < 1 || frames[0] !== wf) begin
                errors++; $display("FAIL sat_frame[%0d] got=%h want=%h", i, frames.size() > 0 ? frames[0] : 64'hx, wf);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc[4] = '{-1, -1, -1, -1};
        int want_acc[4] = '{1, 9, 521, 1033};
        int k = 0, g = 0;
        logic [31:0] base = 32'h0001_0000;
        do_reset();
        sample_in = base; gain_shift = 6'd0; sample_valid = 1'b1;
        while (k < 4 && g < 3000) begin
            if (sample_ready) begin
                acc[k] = cyc + 1;
                @(negedge clk);
                k++;
                sample_in = base + 32'(k);
            end else begin
                @(negedge clk);
            end
            g++;
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc[i] !== want_acc[i]) begin
                errors++; $display("FAIL bp_accept[%0d] got=%0d want=%0d", i, acc[i], want_acc[i]);
            end
        end
        wait_frames(3);
        checks++;
        if (frames.size() < 3) begin
            errors++; $display("FAIL bp_frames got=%0d want>=3", frames.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [63:0] wf;
                wf = {24'h010000 + 24'(i), 8'h00, 24'h010000 + 24'(i), 8'h00};
                checks++;
                if (frames[i] !== wf) begin
                    errors++; $display("FAIL bp_frame[%0d] got=%h want=%h", i, frames[i], wf);
                end
            end
        end
    endtask

    task automatic test_underrun();
        bit ok; logic cs; int ac;
        do_reset();
        send(32'h0000_0100, 6'd0, ok, cs, ac);
        wait_cyc(1600);
        checks++;
        if (ur_log.size() !== 3) begin
            errors++; $display("FAIL ur_count got=%0d want=3", ur_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ur_log[i] !== 520 + 512 * i) begin
                    errors++; $display("FAIL ur_cycle[%0d] got=%0d want=%0d", i, ur_log[i], 520 + 512 * i);
                end
            end
        end
        wait_frames(3);
        checks++;
        if (frames.size() < 3 || frames[1] !== 64'h00010000_00010000 || frames[2] !== 64'h00010000_00010000) begin
            errors++; $display("FAIL ur_repeat got=%0d frames last=%h want=0001000000010000",
                               frames.size(), frames.size() > 0 ? frames[frames.size()-1] : 64'hx);
        end
    endtask

    task automatic test_simultaneous();
        bit ok; logic cs; int ac;
        do_reset();
        send(32'h0000_0100, 6'd0, ok, cs, ac);
        wait_cyc(519);
        sample_in = 32'h0000_0300; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        checks++;
        if (underrun !== 1'b1 || sample_ready !== 1'b0) begin
            errors++; $display("FAIL simul_load underrun/ready got=%b%b want=10", underrun, sample_ready);
        end
        wait_cyc(1032);
        checks++;
        if (sample_ready !== 1'b1 || underrun !== 1'b0) begin
            errors++; $display("FAIL simul_next_load ready/underrun got=%b%b want=10", sample_ready, underrun);
        end
        wait_frames(3);
        checks++;
        if (frames.size() < 3 || frames[1] !== 64'h00010000_00010000 || frames[2] !== 64'h00030000_00030000) begin
            errors++; $display("FAIL simul_frames got=%0d f1=%h f2=%h want f1=0001000000010000 f2=0003000000030000",
                               frames.size(), frames.size() > 1 ? frames[1] : 64'hx, frames.size() > 2 ? frames[2] : 64'hx);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok; logic cs; int ac;
        do_reset();
        send(32'h0012_3456, 6'd0, ok, cs, ac);
        send(32'h00AB_CDEF, 6'd0, ok, cs, ac);
        wait_cyc(340);
        checks++;
        if (lrclk !== 1'b1 || sample_ready !== 1'b0) begin
            errors++; $display("FAIL premid lrclk/ready got=%b%b want=10", lrclk, sample_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bclk, lrclk, sdata, clip, underrun, sample_ready} !== 6'b000001) begin
            errors++; $display("FAIL mid_reset_outputs got=%b want=000001", {bclk, lrclk, sdata, clip, underrun, sample_ready});
        end
        repeat (2) @(negedge clk);
        frames.delete();
        ur_log.delete();
        rst = 1'b0;
        wait_cyc(8);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL mid_underrun got=%b want=1", underrun); end
        wait_frames(1);
        checks++;
        if (frames.size() < 1 || frames[0] !== 64'h0) begin
            errors++; $display("FAIL mid_frame got=%h want=0", frames.size() > 0 ? frames[0] : 64'hx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_underrun();
        test_simultaneous();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Output stage of the effects chain: consumes the 32-bit signed mono sample stream leaving the delay effect and serialises it as a standard I2S frame, with the same sample on left and right, for the board DAC. Each sample passes through a per-sample arithmetic right shift and saturates to the DAC word width. The block generates BCLK and LRCLK itself from the system clock. If no new sample is waiting at a frame boundary, it repeats the previous sample.

## Interface
Parameters:
- DATA_WIDTH, 32, width of incoming signed samples
- OUT_WIDTH, 24, DAC word width; must be ≤ 32
- BCLK_DIV, 4, system clocks per BCLK half-period; must be ≥ 1

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous and active-high
- sample_in  in  DATA_WIDTH  signed sample
- gain_shift  in  $clog2(DATA_WIDTH)+1  arithmetic right-shift amount, captured with the sample
- sample_valid  in  1  sample_in and gain_shift are valid
- sample_ready  out  1  holding register empty
- bclk  out  1  I2S bit clock
- lrclk  out  1  I2S word select; 0 selects left
- sdata  out  1  I2S serial data
- clip  out  1  one-cycle pulse: the accepted sample saturated
- underrun  out  1  one-cycle pulse: a frame started with no new sample

## Operation
- **Handshake.** A sample is accepted on a clk edge where sample_valid && sample_ready.
  - On acceptance, compute shifted = $signed(sample_in) >>> gain_shift. A gain_shift ≥ DATA_WIDTH gives all sign bits.
  - Saturate shifted to OUT_WIDTH: values above 2^(OUT_WIDTH-1)-1 become 0x7FFFFF; values below -2^(OUT_WIDTH-1) become 0x800000 (OUT_WIDTH=24).
  - Write the result to the holding register and mark it full.
  - clip pulses in the cycle after acceptance when saturation occurred.
- **sample_ready** is the inverse of the holding-full flag and is a registered output.
- **Bit clock.** A divider counter toggles bclk every BCLK_DIV clk cycles.
- **Bit counter.** bit_cnt (6 bits, mod 64) advances on every bclk falling-edge event, i.e. the clk edge at which bclk goes 1→0.
- **Frame layout.** 64 BCLKs per frame, 32 per channel.
  - Slot word = {sample[OUT_WIDTH-1:0], (32-OUT_WIDTH) zeros}, sent MSB first.
  - For bit_cnt n in 0..31: sdata = word[31-n] (left). For n in 32..63: sdata = word[63-n] (right).
  - lrclk = 0 for bit_cnt ∈ {63, 0..30}; lrclk = 1 for bit_cnt ∈ {31..62}. This gives the I2S one-BCLK lead before each MSB.
- **Frame load.** On the falling-edge event where bit_cnt becomes 63:
  - If holding is full: copy it to the frame register and clear holding-full.
  - Otherwise: keep the previous frame register value and pulse underrun.
- **Load and accept in the same cycle.** When holding is empty at a load event and a sample is accepted in that same cycle, the accepted sample goes to holding and serves the next frame. The current frame repeats the old sample and underrun pulses.
- **Registered outputs.** sdata, lrclk and bclk are all registered and change on the same clk edge; data therefore changes on BCLK falling edges.

## Timing
- **Reset values:**
  - bclk=0, lrclk=0, sdata=0, clip=0, underrun=0, sample_ready=1
  - divider=0, bit_cnt=62
  - frame register=0, holding empty
- **Reset mid-frame:** all of the above apply immediately (asynchronous). Any held sample is discarded.
- **After reset release:**
  - First bclk rise occurs BCLK_DIV clks after the first active edge.
  - First falling event comes at 2·BCLK_DIV: bit_cnt becomes 63 and the frame load occurs.
- **Frame period** = 128·BCLK_DIV clk cycles. The sample rate is f_clk/(128·BCLK_DIV).
- **Acceptance to serialisation:**
  - Acceptance to holding register: 1 clk.
  - The holding register is consumed at the next load event.
  - Left MSB appears 1 BCLK after the load.
- **Throughput:** at most one sample per frame. sample_ready stays low from acceptance until the next load event.

## Test plan
- **Basic frame.** Reset, then send sample_in=0x00123456 with gain_shift=0.
  - Left and right slots both carry 0x123456 followed by 8 zero bits, MSB first.
  - lrclk falls one BCLK before the left MSB.
  - No clip.
- **Saturation.**
  - 0x7FFFFFFF, shift 0 → 0x7FFFFF with clip pulse.
  - 0x80000000, shift 0 → 0x800000 with clip pulse.
  - 0x7FFFFFFF, shift 8 → 0x7FFFFF with no clip.
  - 0xFFFFFFFF, shift 40 → 0xFFFFFF.
- **Backpressure.** Hold sample_valid high with a new value every accepted cycle.
  - Exactly one acceptance per 128·BCLK_DIV clks.
  - sample_ready re-rises 1 clk after each load event.
  - Each frame carries consecutive samples.
- **Underrun.** Send one sample (0x000100), then stop.
  - Subsequent frames repeat 0x000100.
  - underrun pulses once per frame, one clk wide, at the bit_cnt=63 event.
- **Simultaneous load and accept.** Assert valid exactly on a load event while holding is empty.
  - underrun pulses and the old sample is sent.
  - The new sample appears in the following frame.
- **Reset mid-frame.** Assert rst during the right slot.
  - All outputs return to their reset values asynchronously.
  - After release the first frame outputs 0 with an underrun pulse unless a sample was accepted first.
